// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, branch types,
// multicycle FSM states and iteration count.
package exe_pkg;

   localparam int unsigned MC_ITER = 32;

   localparam logic [3:0] CMD_ADD  = 4'd0;
   localparam logic [3:0] CMD_SUB  = 4'd1;
   localparam logic [3:0] CMD_AND  = 4'd2;
   localparam logic [3:0] CMD_OR   = 4'd3;
   localparam logic [3:0] CMD_NOR  = 4'd4;
   localparam logic [3:0] CMD_XOR  = 4'd5;
   localparam logic [3:0] CMD_SLL  = 4'd6;
   localparam logic [3:0] CMD_SRL  = 4'd7;
   localparam logic [3:0] CMD_SRA  = 4'd8;
   localparam logic [3:0] CMD_MUL  = 4'd10;
   localparam logic [3:0] CMD_DIVU = 4'd11;

   localparam logic [1:0] BR_NONE = 2'd0;
   localparam logic [1:0] BR_BEZ  = 2'd1;
   localparam logic [1:0] BR_BNE  = 2'd2;
   localparam logic [1:0] BR_JMP  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } mc_state_e;

endpackage

// File: rtl/mc_muldiv.sv
// Iterative 32-step unit: shift-add multiply (low word) and restoring
// unsigned divide (quotient). o_busy doubles as the pipeline stall request.
module mc_muldiv
   import exe_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   input  logic        i_is_div,
   input  logic [31:0] i_op_a,
   input  logic [31:0] i_op_b,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_result
);

   mc_state_e   r_state;
   mc_state_e   w_state_next;
   logic [4:0]  r_count;
   logic        r_is_div;
   logic [31:0] r_a;       // multiplicand, or dividend shifting into quotient
   logic [31:0] r_b;       // multiplier, or divisor
   logic [31:0] r_acc;     // product accumulator, or partial remainder
   logic [31:0] r_result;

   logic        w_last;
   logic [31:0] w_mul_acc;
   logic [32:0] w_shift_rem;
   logic [31:0] w_diff;
   logic        w_ge;
   logic [31:0] w_rem_next;
   logic [31:0] w_quot_next;

   assign w_last      = (r_count == 5'(MC_ITER - 1));
   assign w_mul_acc   = r_b[0] ? (r_acc + r_a) : r_acc;
   assign w_shift_rem = {r_acc, r_a[31]};
   assign w_ge        = (w_shift_rem >= {1'b0, r_b});
   assign w_diff      = w_shift_rem[31:0] - r_b;
   assign w_rem_next  = w_ge ? w_diff : w_shift_rem[31:0];
   assign w_quot_next = {r_a[30:0], w_ge};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      o_busy       = 1'b0;
      o_done       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            o_busy = i_start;
            if (i_start) w_state_next = ST_BUSY;
         end
         ST_BUSY: begin
            o_busy = 1'b1;
            if (w_last) w_state_next = ST_DONE;
         end
         ST_DONE: begin
            o_done       = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count  <= '0;
         r_is_div <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_a      <= i_op_a;
                  r_b      <= i_op_b;
                  r_acc    <= '0;
                  r_count  <= '0;
                  r_is_div <= i_is_div;
               end
            end
            ST_BUSY: begin
               r_count <= r_count + 5'd1;
               if (r_is_div) begin
                  r_a   <= w_quot_next;
                  r_acc <= w_rem_next;
               end else begin
                  r_a   <= r_a << 1;
                  r_b   <= r_b >> 1;
                  r_acc <= w_mul_acc;
               end
               if (w_last) r_result <= r_is_div ? w_quot_next : w_mul_acc;
            end
            default: ;
         endcase
      end
   end

   assign o_result = r_result;

endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: combinational ALU and branch resolution, with MUL/DIVU
// delegated to the iterative unit that stalls the front of the pipeline.
module exe_stage
   import exe_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] val1,
   input  logic [31:0] val2,
   input  logic [31:0] reg2,
   input  logic [3:0]  exe_cmd,
   input  logic [1:0]  br_type,
   input  logic [31:0] pc,
   output logic [31:0] alu_result,
   output logic        br_taken,
   output logic [31:0] br_addr,
   output logic        mc_stall
);

   logic        w_is_mc;
   logic        w_mc_busy;
   logic        w_mc_done;
   logic [31:0] w_mc_result;
   logic [31:0] w_alu;
   logic [4:0]  w_shamt;
   logic        w_br_cond;

   assign w_is_mc = (exe_cmd == CMD_MUL) || (exe_cmd == CMD_DIVU);
   assign w_shamt = val2[4:0];

   mc_muldiv u_mc (
      .clk      (clk),
      .rst      (rst),
      .i_start  (w_is_mc),
      .i_is_div (exe_cmd == CMD_DIVU),
      .i_op_a   (val1),
      .i_op_b   (val2),
      .o_busy   (w_mc_busy),
      .o_done   (w_mc_done),
      .o_result (w_mc_result)
   );

   always_comb begin
      w_alu = '0;
      case (exe_cmd)
         CMD_ADD: w_alu = val1 + val2;
         CMD_SUB: w_alu = val1 - val2;
         CMD_AND: w_alu = val1 & val2;
         CMD_OR:  w_alu = val1 | val2;
         CMD_NOR: w_alu = ~(val1 | val2);
         CMD_XOR: w_alu = val1 ^ val2;
         CMD_SLL: w_alu = val1 << w_shamt;
         CMD_SRL: w_alu = val1 >> w_shamt;
         CMD_SRA: w_alu = $signed(val1) >>> w_shamt;
         default: w_alu = '0;
      endcase
   end

   always_comb begin
      w_br_cond = 1'b0;
      case (br_type)
         BR_BEZ:  w_br_cond = (val1 == '0);
         BR_BNE:  w_br_cond = (val1 != reg2);
         BR_JMP:  w_br_cond = 1'b1;
         default: w_br_cond = 1'b0;
      endcase
   end

   // In DONE the ID/EX inputs still hold the frozen MUL/DIVU; the latched result wins.
   assign alu_result = w_mc_done ? w_mc_result : w_alu;
   assign mc_stall   = w_mc_busy;
   assign br_taken   = w_br_cond & ~w_mc_busy;
   assign br_addr    = pc + {val2[29:0], 2'b00};

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed vector table, randomized ops
// against an arithmetic reference model, and multicycle MUL/DIVU sequences.
module tb_exe_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] val1, val2, reg2, pc;
   logic [3:0]  exe_cmd;
   logic [1:0]  br_type;
   logic [31:0] alu_result;
   logic        br_taken;
   logic [31:0] br_addr;
   logic        mc_stall;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   exe_stage dut (
      .clk        (clk),
      .rst        (rst),
      .val1       (val1),
      .val2       (val2),
      .reg2       (reg2),
      .exe_cmd    (exe_cmd),
      .br_type    (br_type),
      .pc         (pc),
      .alu_result (alu_result),
      .br_taken   (br_taken),
      .br_addr    (br_addr),
      .mc_stall   (mc_stall)
   );

   typedef struct {
      logic [3:0]  cmd;
      logic [1:0]  br;
      logic [31:0] v1;
      logic [31:0] v2;
      logic [31:0] r2;
      logic [31:0] pc;
      logic [31:0] res;
      logic        taken;
      logic [31:0] addr;
   } vec_t;

   vec_t vecs[18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] prod;
      int unsigned sh;
      sh = b % 32;
      case (c)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return ~(a | b);
         4'd5:  return a ^ b;
         4'd6:  return a << sh;
         4'd7:  return a >> sh;
         4'd8:  return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
         4'd10: begin prod = 64'(a) * 64'(b); return prod[31:0]; end
         4'd11: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic ref_taken(input logic [1:0] bt, input logic [31:0] a, input logic [31:0] r);
      return (bt == 2'd1 && a == 0) || (bt == 2'd2 && a != r) || (bt == 2'd3);
   endfunction

   task automatic set_in(input logic [3:0] c, input logic [1:0] bt, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r, input logic [31:0] p);
      exe_cmd = c; br_type = bt; val1 = a; val2 = b; reg2 = r; pc = p;
   endtask

   // Expects to be entered just after a rising edge with the unit idle.
   task automatic run_mc(input string name, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input bit perturb);
      int stall;
      logic [31:0] exp;
      exp = ref_alu(c, a, b);
      stall = 0;
      set_in(c, 2'd0, a, b, 32'h0, 32'h0);
      #1;
      while (mc_stall === 1'b1 && stall < 100) begin
         chk({name, "_brtaken_in_stall"}, {31'h0, br_taken}, 32'h0);
         stall++;
         @(posedge clk); #1;
         if (perturb) begin
            val1 = $urandom;
            val2 = $urandom;
         end
      end
      chk({name, "_stall_cycles"}, 32'(stall), 32'd33);
      chk({name, "_result"}, alu_result, exp);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      //                cmd    br    v1            v2            r2     pc          res           tk    addr
      vecs[0]  = '{4'd0,  2'd0, 32'h7FFFFFFF, 32'h00000001, 32'h0, 32'h0,      32'h80000000, 1'b0, 32'h00000004};
      vecs[1]  = '{4'd8,  2'd0, 32'h80000000, 32'h00000004, 32'h0, 32'h0,      32'hF8000000, 1'b0, 32'h00000010};
      vecs[2]  = '{4'd8,  2'd0, 32'h7FFFFFF0, 32'h00000004, 32'h0, 32'h0,      32'h07FFFFFF, 1'b0, 32'h00000010};
      vecs[3]  = '{4'd1,  2'd0, 32'h00000000, 32'h00000001, 32'h0, 32'h0,      32'hFFFFFFFF, 1'b0, 32'h00000004};
      vecs[4]  = '{4'd2,  2'd0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 32'h0,      32'h00F000F0, 1'b0, 32'h3FC03FC0};
      vecs[5]  = '{4'd3,  2'd0, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0, 32'h0,      32'hFFFFFFFF, 1'b0, 32'h3C3C3C3C};
      vecs[6]  = '{4'd4,  2'd0, 32'h00000000, 32'h00000000, 32'h0, 32'h0,      32'hFFFFFFFF, 1'b0, 32'h00000000};
      vecs[7]  = '{4'd5,  2'd0, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h0, 32'h0,      32'h55555555, 1'b0, 32'hFFFFFFFC};
      vecs[8]  = '{4'd6,  2'd0, 32'h00000001, 32'h0000001F, 32'h0, 32'h0,      32'h80000000, 1'b0, 32'h0000007C};
      vecs[9]  = '{4'd7,  2'd0, 32'h80000000, 32'h00000021, 32'h0, 32'h0,      32'h40000000, 1'b0, 32'h00000084};
      vecs[10] = '{4'd9,  2'd0, 32'h00000005, 32'h00000005, 32'h0, 32'h0,      32'h00000000, 1'b0, 32'h00000014};
      vecs[11] = '{4'd15, 2'd0, 32'h00000005, 32'h00000005, 32'h0, 32'h0,      32'h00000000, 1'b0, 32'h00000014};
      vecs[12] = '{4'd0,  2'd2, 32'h00000003, 32'h00000002, 32'h4, 32'h100,    32'h00000005, 1'b1, 32'h00000108};
      vecs[13] = '{4'd0,  2'd1, 32'h00000001, 32'h00000000, 32'h0, 32'h200,    32'h00000001, 1'b0, 32'h00000200};
      vecs[14] = '{4'd0,  2'd1, 32'h00000000, 32'hFFFFFFFF, 32'h0, 32'h200,    32'hFFFFFFFF, 1'b1, 32'h000001FC};
      vecs[15] = '{4'd0,  2'd3, 32'h00000000, 32'h00000010, 32'h0, 32'h1000,   32'h00000010, 1'b1, 32'h00001040};
      vecs[16] = '{4'd0,  2'd2, 32'h00000007, 32'h00000001, 32'h7, 32'h0,      32'h00000008, 1'b0, 32'h00000004};
      vecs[17] = '{4'd12, 2'd0, 32'h12345678, 32'h00000003, 32'h0, 32'h0,      32'h00000000, 1'b0, 32'h0000000C};

      rst = 1'b1;
      set_in(4'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_alu_result", alu_result, 32'h0);
      chk("reset_br_taken", {31'h0, br_taken}, 32'h0);
      chk("reset_br_addr", br_addr, 32'h0);
      chk("reset_mc_stall", {31'h0, mc_stall}, 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 18; i++) begin
         set_in(vecs[i].cmd, vecs[i].br, vecs[i].v1, vecs[i].v2, vecs[i].r2, vecs[i].pc);
         #2;
         chk($sformatf("vec%0d_result", i), alu_result, vecs[i].res);
         chk($sformatf("vec%0d_taken", i), {31'h0, br_taken}, {31'h0, vecs[i].taken});
         chk($sformatf("vec%0d_addr", i), br_addr, vecs[i].addr);
         chk($sformatf("vec%0d_stall", i), {31'h0, mc_stall}, 32'h0);
         @(posedge clk); #1;
      end

      run_mc("mul_7x6", 4'd10, 32'd7, 32'd6, 1'b0);
      run_mc("mul_ffff_x2", 4'd10, 32'hFFFFFFFF, 32'd2, 1'b0);
      run_mc("divu_100_7", 4'd11, 32'd100, 32'd7, 1'b0);
      run_mc("divu_5_0", 4'd11, 32'd5, 32'd0, 1'b0);
      run_mc("b2b_mul_3x4", 4'd10, 32'd3, 32'd4, 1'b0);
      run_mc("b2b_mul_5x5", 4'd10, 32'd5, 32'd5, 1'b0);
      set_in(4'd0, 2'd0, 32'd1, 32'd2, 32'h0, 32'h0);
      #1;
      chk("after_b2b_no_reissue", {31'h0, mc_stall}, 32'h0);
      chk("after_b2b_add", alu_result, 32'd3);
      @(posedge clk); #1;
      run_mc("mul_perturbed", 4'd10, 32'h00012345, 32'h00000777, 1'b1);
      run_mc("divu_perturbed", 4'd11, 32'hDEADBEEF, 32'h00000013, 1'b1);

      // Reset while the unit is at iteration count 10.
      set_in(4'd10, 2'd0, 32'd9, 32'd9, 32'h0, 32'h0);
      repeat (11) @(posedge clk);
      #1;
      chk("pre_reset_busy", {31'h0, mc_stall}, 32'h1);
      rst = 1'b1;
      set_in(4'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
      #1;
      chk("midbusy_reset_stall", {31'h0, mc_stall}, 32'h0);
      chk("midbusy_reset_result", alu_result, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      run_mc("post_reset_mul_2x3", 4'd10, 32'd2, 32'd3, 1'b0);

      for (int i = 0; i < 40; i++) begin
         logic [3:0]  c;
         logic [1:0]  bt;
         logic [31:0] a, b, r, p;
         c  = 4'($urandom_range(0, 15));
         if (c == 4'd10 || c == 4'd11) c = 4'd0;
         bt = 2'($urandom_range(0, 3));
         a  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         b  = $urandom;
         r  = ($urandom_range(0, 2) == 0) ? a : $urandom;
         p  = $urandom & 32'hFFFF_FFFC;
         set_in(c, bt, a, b, r, p);
         #2;
         chk($sformatf("rnd%0d_result", i), alu_result, ref_alu(c, a, b));
         chk($sformatf("rnd%0d_taken", i), {31'h0, br_taken}, {31'h0, ref_taken(bt, a, r)});
         chk($sformatf("rnd%0d_addr", i), br_addr, p + b * 32'd4);
         chk($sformatf("rnd%0d_stall", i), {31'h0, mc_stall}, 32'h0);
         @(posedge clk); #1;
      end

      for (int i = 0; i < 6; i++) begin
         logic [3:0]  c;
         logic [31:0] a, b;
         c = (i % 2 == 0) ? 4'd10 : 4'd11;
         a = $urandom;
         b = (c == 4'd11 && $urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
         if (c == 4'd11 && i == 5) b = 32'h0;
         run_mc($sformatf("rnd_mc%0d", i), c, a, b, (i % 3) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
